// File: rtl/composite_line_scheduler.sv
// composite_line_scheduler
// Sequences per-line render requests against the NTSC composite timing pulses.
// The line buffers are double-buffered and swap at every next_line. A request
// raised while the previous one is still pending or busy aborts the old render
// and flags an overrun.
// Optional feature: define COMPOSITE_SCHED_LINE_IRQ_EN to build the line-compare
// interrupt. Without it, line_irq is tied low and irq_line is unused.
module composite_line_scheduler #(
  parameter int unsigned ACTIVE_LINES = 240,
  parameter int unsigned LINE_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_frame,
  input  logic              next_line,
  input  logic              vblank_pulse,
  input  logic              current_field,
  input  logic              interlace_en,
  input  logic [LINE_W-1:0] irq_line,
  output logic              render_req,
  input  logic              render_ack,
  input  logic              render_done,
  output logic              render_abort,
  output logic [LINE_W-1:0] render_line,
  output logic              render_buf,
  output logic              display_buf,
  output logic              line_irq,
  output logic              vblank_irq,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam logic [8:0] ActiveLinesW = 9'(ACTIVE_LINES);

  typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

  state_e            state_q;
  logic [8:0]        field_line_q;
  logic [8:0]        new_line;
  logic              arm;
  logic              pend_q;
  logic [LINE_W-1:0] line_ext;
  logic [LINE_W-1:0] new_render_line;
  logic [LINE_W-1:0] render_line_q;
  logic              render_buf_q;
  logic              render_abort_q;
  logic              line_irq_q;
  logic              vblank_irq_q;
  logic              overrun_q;
  logic              hit_new;
  logic              hit_held;

  // Next field line value and whether it arms a render request.
  always_comb begin
    new_line = field_line_q;
    if (next_frame) begin
      new_line = '0;
    end else if (next_line && (field_line_q < ActiveLinesW)) begin
      new_line = field_line_q + 9'd1;
    end
    arm             = next_frame | (next_line & (new_line < ActiveLinesW));
    line_ext        = LINE_W'(new_line);
    new_render_line = interlace_en ? {line_ext[LINE_W-2:0], current_field} : line_ext;
  end

`ifdef COMPOSITE_SCHED_LINE_IRQ_EN
  // Compare both the freshly armed line and the line held across an abort.
  always_comb begin
    hit_new  = (new_render_line == irq_line);
    hit_held = (render_line_q == irq_line);
  end
`else
  logic unused_irq_line;
  // Compare logic not built: no line interrupts.
  always_comb begin
    hit_new         = 1'b0;
    hit_held        = 1'b0;
    unused_irq_line = ^irq_line;
  end
`endif

  // Line counter, buffer swap, request FSM, overrun and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      field_line_q   <= '0;
      pend_q         <= 1'b0;
      render_line_q  <= '0;
      render_buf_q   <= 1'b0;
      render_abort_q <= 1'b0;
      line_irq_q     <= 1'b0;
      vblank_irq_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      render_abort_q <= 1'b0;
      line_irq_q     <= 1'b0;
      vblank_irq_q   <= vblank_pulse;

      if (next_frame || next_line) begin
        field_line_q <= new_line;
      end
      if (next_line) begin
        render_buf_q <= ~render_buf_q;
      end

      // A coincident overrun set below overrides this clear.
      if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (arm) begin
            render_line_q <= new_render_line;
            line_irq_q    <= hit_new;
            pend_q        <= 1'b0;
            state_q       <= StReq;
          end else if (pend_q) begin
            // Re-issue the request latched when the previous render was aborted.
            line_irq_q <= hit_held;
            pend_q     <= 1'b0;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (arm) begin
            render_abort_q <= 1'b1;
            overrun_q      <= 1'b1;
            render_line_q  <= new_render_line;
            pend_q         <= 1'b1;
            state_q        <= StIdle;
          end else if (render_ack) begin
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (render_done) begin
            // Done wins over a coincident new line: plain re-arm, no overrun.
            if (arm) begin
              render_line_q <= new_render_line;
              line_irq_q    <= hit_new;
              state_q       <= StReq;
            end else begin
              state_q <= StIdle;
            end
          end else if (arm) begin
            render_abort_q <= 1'b1;
            overrun_q      <= 1'b1;
            render_line_q  <= new_render_line;
            pend_q         <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign render_req   = (state_q == StReq);
  assign render_abort = render_abort_q;
  assign render_line  = render_line_q;
  assign render_buf   = render_buf_q;
  assign display_buf  = ~render_buf_q;
  assign line_irq     = line_irq_q;
  assign vblank_irq   = vblank_irq_q;
  assign overrun      = overrun_q;

endmodule
